// File: rtl/inst_queue_pkg.sv
// Shared widths and depth for the instruction queue and its neighbours in the front end.
package inst_queue_pkg;

    localparam int InstWidth = 32;
    localparam int AddrWidth = 32;
    localparam int IQ_SIZE   = 16;

    typedef struct packed {
        logic [InstWidth-1:0] inst;
        logic [AddrWidth-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Show-ahead circular instruction FIFO between fetch and decode, flushed on misprediction.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int IQ_SIZE  = inst_queue_pkg::IQ_SIZE,
    parameter int IQ_PTR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 IF_inst_valid,
    input  logic [InstWidth-1:0] IF_inst,
    input  logic [AddrWidth-1:0] IF_pc,
    output logic                 IQ_is_full,
    output logic                 IQ_inst_valid,
    output logic [InstWidth-1:0] IQ_inst,
    output logic [AddrWidth-1:0] IQ_pc,
    input  logic                 IQ_enable,
    input  logic                 ROB_clear
);

    localparam logic [IQ_PTR_W:0] FULL_CNT = IQ_SIZE[IQ_PTR_W:0];

    iq_entry_t            mem [IQ_SIZE];
    logic [IQ_PTR_W-1:0]  head;
    logic [IQ_PTR_W-1:0]  tail;
    logic [IQ_PTR_W:0]    count;
    logic                 push;
    logic                 pop;

    // Full comes only from registers, so a pop never frees a slot in the same cycle.
    assign IQ_is_full    = (count == FULL_CNT);
    assign IQ_inst_valid = (count != '0);
    assign IQ_inst       = IQ_inst_valid ? mem[head].inst : '0;
    assign IQ_pc         = IQ_inst_valid ? mem[head].pc   : '0;

    assign push = IF_inst_valid && !IQ_is_full    && rdy && !ROB_clear;
    assign pop  = IQ_enable     &&  IQ_inst_valid && rdy && !ROB_clear;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (ROB_clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    // Storage has no reset; stale contents are masked by count.
    always_ff @(posedge clk) begin
        if (rst && push) mem[tail] <= '{inst: IF_inst, pc: IF_pc};
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, latency, full/empty, wrap, flush, stall and mid-run reset.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rdy;
    logic                 IF_inst_valid;
    logic [InstWidth-1:0] IF_inst;
    logic [AddrWidth-1:0] IF_pc;
    logic                 IQ_is_full;
    logic                 IQ_inst_valid;
    logic [InstWidth-1:0] IQ_inst;
    logic [AddrWidth-1:0] IQ_pc;
    logic                 IQ_enable;
    logic                 ROB_clear;

    int n_cmp  = 0;
    int n_fail = 0;

    inst_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .IF_inst_valid(IF_inst_valid), .IF_inst(IF_inst), .IF_pc(IF_pc),
        .IQ_is_full(IQ_is_full), .IQ_inst_valid(IQ_inst_valid),
        .IQ_inst(IQ_inst), .IQ_pc(IQ_pc),
        .IQ_enable(IQ_enable), .ROB_clear(ROB_clear)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 32'(IQ_inst_valid), 32'd0);
        chk({tag, "_full"},  32'(IQ_is_full),    32'd0);
        chk({tag, "_inst"},  IQ_inst,            32'd0);
        chk({tag, "_pc"},    IQ_pc,              32'd0);
    endtask

    task automatic push_one(input logic [31:0] pc);
        IF_inst_valid = 1'b1;
        IF_pc         = pc;
        IF_inst       = 32'hA000_0000 | pc;
        step();
        IF_inst_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; IF_inst_valid = 1'b0; IF_inst = '0; IF_pc = '0;
        IQ_enable = 1'b0; ROB_clear = 1'b0;

        // reset with stimulus asserted must still leave the queue empty
        IF_inst_valid = 1'b1; IF_pc = 32'h55;
        step(); step();
        chk_empty("in_reset");
        IF_inst_valid = 1'b0;
        rst = 1'b1;
        step();
        chk_empty("post_reset");

        // first push: no bypass, visible one cycle later
        IF_inst_valid = 1'b1; IF_pc = 32'h0; IF_inst = 32'h0000_0013;
        #1;
        chk("same_cycle_valid", 32'(IQ_inst_valid), 32'd0);
        step();
        IF_inst_valid = 1'b0;
        chk("lat1_valid", 32'(IQ_inst_valid), 32'd1);
        chk("lat1_pc",    IQ_pc,   32'h0);
        chk("lat1_inst",  IQ_inst, 32'h0000_0013);
        IQ_enable = 1'b1;
        step();
        IQ_enable = 1'b0;
        chk("drain1_valid", 32'(IQ_inst_valid), 32'd0);

        // fill 16 entries
        for (int i = 0; i < 16; i++) begin
            push_one(32'(4 * i));
            if (i == 14) chk("fill15_full", 32'(IQ_is_full), 32'd0);
        end
        chk("fill16_full", 32'(IQ_is_full), 32'd1);
        push_one(32'h40);
        chk("over_full",  32'(IQ_is_full), 32'd1);
        chk("over_head",  IQ_pc, 32'h0);

        // pop+push while full: pop only, freed slot usable next cycle
        IF_inst_valid = 1'b1; IF_pc = 32'h40; IF_inst = 32'hA000_0040; IQ_enable = 1'b1;
        step();
        IQ_enable = 1'b0; IF_inst_valid = 1'b0;
        chk("pp_full_full", 32'(IQ_is_full), 32'd0);
        chk("pp_full_head", IQ_pc, 32'h4);
        push_one(32'h44);
        chk("refill_full", 32'(IQ_is_full), 32'd1);

        IQ_enable = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("pop_order_pc", IQ_pc, 32'(4 * i));
            chk("pop_order_inst", IQ_inst, 32'hA000_0000 | 32'(4 * i));
            step();
        end
        chk("pop_last_pc", IQ_pc, 32'h44);
        step();
        chk("pop_empty_valid", 32'(IQ_inst_valid), 32'd0);
        chk("pop_empty_pc", IQ_pc, 32'h0);
        step();
        chk("pop_on_empty", 32'(IQ_inst_valid), 32'd0);
        IQ_enable = 1'b0;

        // steady state at count 5, pointers wrap several times
        for (int i = 0; i < 5; i++) push_one(32'h100 + 32'(4 * i));
        IQ_enable = 1'b1; IF_inst_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            IF_pc   = 32'h100 + 32'(4 * (k + 5));
            IF_inst = 32'hA000_0000 | IF_pc;
            chk("ss_head", IQ_pc, 32'h100 + 32'(4 * k));
            step();
        end
        IF_inst_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("ss_cnt5_last", IQ_pc, 32'h100 + 32'(4 * 24));
        IQ_enable = 1'b0;
        // 1 entry left; add 7 to reach 8
        for (int i = 0; i < 7; i++) push_one(32'h180 + 32'(4 * i));
        chk("pre_clear_head", IQ_pc, 32'h100 + 32'(4 * 24));

        // flush wins over simultaneous push and pop
        ROB_clear = 1'b1; IF_inst_valid = 1'b1; IF_pc = 32'hBEEF; IQ_enable = 1'b1;
        step();
        ROB_clear = 1'b0; IF_inst_valid = 1'b0; IQ_enable = 1'b0;
        chk_empty("flush");
        step();
        chk("flush_no_push", 32'(IQ_inst_valid), 32'd0);

        // stall: rdy=0 freezes everything
        push_one(32'h200);
        push_one(32'h204);
        rdy = 1'b0; ROB_clear = 1'b1; IF_inst_valid = 1'b1; IF_pc = 32'h2FF; IQ_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", 32'(IQ_inst_valid), 32'd1);
            chk("stall_pc", IQ_pc, 32'h200);
        end
        rdy = 1'b1; ROB_clear = 1'b0; IF_pc = 32'h208; IF_inst = 32'hA000_0208;
        step();
        IF_inst_valid = 1'b0;
        chk("resume_head", IQ_pc, 32'h204);
        step();
        chk("resume_head2", IQ_pc, 32'h208);
        step();
        chk("resume_empty", 32'(IQ_inst_valid), 32'd0);
        IQ_enable = 1'b0;

        // reset in the middle of operation
        for (int i = 0; i < 10; i++) push_one(32'h300 + 32'(4 * i));
        chk("pre_rst_pc", IQ_pc, 32'h300);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_empty("mid_rst");
        push_one(32'h400);
        chk("post_rst_valid", 32'(IQ_inst_valid), 32'd1);
        chk("post_rst_pc", IQ_pc, 32'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
